// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Multi-cycle instruction sequencer that owns the PC write enable. It fetches
// the instruction at the current PC over a request/acknowledge instruction
// memory port and latches it into the instruction register. It optionally
// waits on a data-memory handshake. It then retires the instruction by pulsing
// the PC and register-file write enables for one cycle.
//
// All control outputs are decoded from the state register only (Moore), so
// there is no combinational path from any input to any output.
//
// Parameters:
//   ADDR_W          width of PC / fetch address
//   TIMEOUT_CYCLES  consecutive ack-less wait cycles before FAULT (0 = never)
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   pc_value          current PC from the PC block
//   halt_req          stop after the current instruction
//   instr_is_mem      current instruction needs data memory (sampled in EXEC)
//   imem_req/addr     instruction fetch request (level) and registered address
//   imem_ack/rdata    single-cycle instruction return
//   instr_out/valid   instruction register and its valid flag
//   dmem_req/ack      data-memory request (level) and single-cycle completion
//   pc_in_en          PC write enable, one-cycle pulse at retire
//   reg_write_en      register-file write enable, coincident with pc_in_en
//   fault             sticky memory-timeout flag
//   state_out         current state encoding, for debug
//
// Optional build macro SEQ_PERF_COUNTERS_EN adds cycle_count and retired_count
// (32-bit, wrapping, cleared by reset).
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_value,
  input  logic              halt_req,
  input  logic              instr_is_mem,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              dmem_req,
  input  logic              dmem_ack,
  output logic              pc_in_en,
  output logic              reg_write_en,
  output logic              fault,
  output logic [2:0]        state_out
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       retired_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT_I = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT_D = 3'd4,
    S_RETIRE = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  // Counter holds 0..TIMEOUT_CYCLES; keep at least one bit when disabled.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // Count value seen on the last allowed wait cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         instr_q, instr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                timeout_hit;

  // Saturating increment of the consecutive-wait counter.
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q >= CNT_LAST);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q     <= S_IDLE;
      imem_addr_q <= '0;
      instr_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = halt_req ? S_HALT : S_FETCH;
      S_FETCH:  state_d = S_WAIT_I;
      S_WAIT_I: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (imem_ack)         state_d = S_EXEC;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_EXEC:   state_d = instr_is_mem ? S_WAIT_D : S_RETIRE;
      S_WAIT_D: begin
        if (dmem_ack)         state_d = S_RETIRE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_RETIRE: state_d = halt_req ? S_HALT : S_FETCH;
      S_HALT:   if (!halt_req) state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: fetch address, instruction register, wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_FETCH: begin
        imem_addr_d = pc_value;
        cnt_d       = '0;
      end
      S_WAIT_I: begin
        if (imem_ack) instr_d = imem_rdata;
        else          cnt_d   = cnt_inc;
      end
      S_EXEC:   cnt_d = '0;
      S_WAIT_D: if (!dmem_ack) cnt_d = cnt_inc;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    instr_valid  = 1'b0;
    pc_in_en     = 1'b0;
    reg_write_en = 1'b0;
    fault        = 1'b0;
    case (state_q)
      S_WAIT_I: imem_req = 1'b1;
      S_EXEC:   instr_valid = 1'b1;
      S_WAIT_D: begin
        dmem_req    = 1'b1;
        instr_valid = 1'b1;
      end
      S_RETIRE: begin
        instr_valid  = 1'b1;
        pc_in_en     = 1'b1;
        reg_write_en = 1'b1;
      end
      S_FAULT:  fault = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = imem_addr_q;
  assign instr_out = instr_q;
  assign state_out = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 32 bits)
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] retired_count_q, retired_count_d;

  always_comb begin
    cycle_count_d   = cycle_count_q + 32'd1;
    retired_count_d = retired_count_q + ((state_q == S_RETIRE) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_count_q   <= '0;
      retired_count_q <= '0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Self-checking bench for pc_fetch_sequencer (TIMEOUT_CYCLES = 8). Each
// instruction is described by its memory latencies and halt behaviour; the
// bench expands that into the expected per-cycle state sequence, drives the
// scheduled acks plus random junk on every input the sequencer must ignore,
// and compares all outputs each cycle against a small model (expected PC,
// fetch address, instruction register and retire count). The PC block is
// modelled as a register advancing by 4 on each retire.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  localparam int ADDR_W = 32;
  localparam int TO     = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, WAIT_I = 3'd2, EXEC = 3'd3,
    WAIT_D = 3'd4, RETIRE = 3'd5, HALT = 3'd6, FAULT = 3'd7
  } st_e;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc_value;
  logic              halt_req, instr_is_mem, imem_ack, dmem_ack;
  logic [31:0]       imem_rdata;
  logic              imem_req, instr_valid, dmem_req, pc_in_en, reg_write_en, fault;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       instr_out;
  logic [2:0]        state_out;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0]       cycle_count, retired_count;
`endif

  pc_fetch_sequencer #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_value     (pc_value),
    .halt_req     (halt_req),
    .instr_is_mem (instr_is_mem),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .pc_in_en     (pc_in_en),
    .reg_write_en (reg_write_en),
    .fault        (fault),
    .state_out    (state_out)
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0]       exp_instr;
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       exp_cycles;
  logic [31:0]       exp_retired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: at the falling edge compare every output against the
  // expected state st, then drive the inputs seen at the next rising edge and
  // advance the model.
  task automatic step(input st_e st, input bit iack, input logic [31:0] rdata,
                      input bit dack, input bit mem, input bit halt, input bit rst);
    @(negedge clock);
    check("state_out",    32'(state_out),    32'(st));
    check("imem_req",     32'(imem_req),     32'(st == WAIT_I));
    check("dmem_req",     32'(dmem_req),     32'(st == WAIT_D));
    check("instr_valid",  32'(instr_valid),  32'(st inside {EXEC, WAIT_D, RETIRE}));
    check("pc_in_en",     32'(pc_in_en),     32'(st == RETIRE));
    check("reg_write_en", 32'(reg_write_en), 32'(st == RETIRE));
    check("fault",        32'(fault),        32'(st == FAULT));
    check("instr_out",    instr_out,         exp_instr);
    check("imem_addr",    imem_addr,         exp_addr);
`ifdef SEQ_PERF_COUNTERS_EN
    check("cycle_count",   cycle_count,   exp_cycles);
    check("retired_count", retired_count, exp_retired);
`endif
    imem_ack     = iack;
    imem_rdata   = rdata;
    dmem_ack     = dack;
    instr_is_mem = mem;
    halt_req     = halt;
    reset        = rst;
    if (!rst) begin
      exp_instr   = '0;
      exp_addr    = '0;
      exp_cycles  = '0;
      exp_retired = '0;
    end else begin
      exp_cycles = exp_cycles + 32'd1;
      case (st)
        FETCH:  exp_addr = pc_value;
        WAIT_I: if (iack) exp_instr = rdata;
        RETIRE: begin
          exp_retired = exp_retired + 32'd1;
          pc_value    = pc_value + 32'd4;
        end
        default: ;
      endcase
    end
  endtask

  // Twenty cycles parked in FAULT with random inputs, then reset and leave
  // IDLE towards FETCH.
  task automatic fault_hold();
    repeat (20) step(FAULT, rb(), $urandom, rb(), rb(), rb(), 1'b1);
    step(FAULT, rb(), $urandom, rb(), rb(), rb(), 1'b0);
    step(IDLE, rb(), $urandom, rb(), rb(), 1'b0, 1'b1);
  endtask

  // One instruction starting in FETCH. ilat/dlat are the number of ack-less
  // wait cycles before the ack (>= TO means a timeout). halt_cycles > 0 halts
  // after retire for that many cycles. rst_at_d >= 0 pulls reset on that
  // WAIT_D cycle; the IDLE cycle afterwards sees a stray dmem_ack.
  task automatic run_instr(input int ilat, input logic [31:0] rdata, input bit is_mem,
                           input int dlat, input int halt_cycles, input int rst_at_d);
    bit acked;
    step(FETCH, rb(), $urandom, rb(), rb(), rb(), 1'b1);
    acked = 1'b0;
    for (int i = 0; i < TO && !acked; i++) begin
      acked = (i == ilat);
      step(WAIT_I, acked, acked ? rdata : $urandom, rb(), rb(), rb(), 1'b1);
    end
    if (!acked) begin
      fault_hold();
      return;
    end
    step(EXEC, rb(), $urandom, rb(), is_mem, rb(), 1'b1);
    if (is_mem) begin
      acked = 1'b0;
      for (int i = 0; i < TO && !acked; i++) begin
        if (i == rst_at_d) begin
          step(WAIT_D, rb(), $urandom, 1'b0, rb(), rb(), 1'b0);
          step(IDLE, rb(), $urandom, 1'b1, rb(), 1'b0, 1'b1);
          return;
        end
        acked = (i == dlat);
        step(WAIT_D, rb(), $urandom, acked, rb(), rb(), 1'b1);
      end
      if (!acked) begin
        fault_hold();
        return;
      end
    end
    step(RETIRE, rb(), $urandom, rb(), rb(), halt_cycles > 0, 1'b1);
    for (int h = 0; h < halt_cycles; h++)
      step(HALT, rb(), $urandom, rb(), rb(), h < halt_cycles - 1, 1'b1);
  endtask

  initial begin
    reset        = 1'b0;
    pc_value     = '0;
    halt_req     = 1'b0;
    instr_is_mem = 1'b0;
    imem_ack     = 1'b0;
    dmem_ack     = 1'b0;
    imem_rdata   = '0;
    exp_instr    = '0;
    exp_addr     = '0;
    exp_cycles   = '0;
    exp_retired  = '0;
    repeat (2) @(posedge clock);

    // Reset state, then IDLE -> HALT on halt_req, HALT -> FETCH on release.
    step(IDLE, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(IDLE, 1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
    step(HALT, rb(), $urandom, rb(), rb(), 1'b1, 1'b1);
    step(HALT, rb(), $urandom, rb(), rb(), 1'b0, 1'b1);

    // Zero-wait non-memory instructions: 4-cycle retire, addresses 0, 4, 8.
    repeat (3) run_instr(0, $urandom, 1'b0, 0, 0, -1);
    // Fetch ack after 3 wait cycles with a known instruction word.
    run_instr(3, 32'h00500093, 1'b0, 0, 0, -1);
    // Memory instruction with one extra data wait: 6 cycles total.
    run_instr(0, $urandom, 1'b1, 1, 0, -1);
    // Ack on the final allowed fetch wait cycle wins over the timeout.
    run_instr(TO - 1, $urandom, 1'b0, 0, 0, -1);
    // No fetch ack: FAULT after TO wait cycles, held until reset.
    run_instr(100, $urandom, 1'b0, 0, 0, -1);
    // Same boundary and timeout on the data side.
    run_instr(0, $urandom, 1'b1, TO - 1, 0, -1);
    run_instr(1, $urandom, 1'b1, 100, 0, -1);
    // Halt after the instruction completes, then resume at the updated PC.
    run_instr(2, $urandom, 1'b0, 0, 3, -1);
    run_instr(0, $urandom, 1'b0, 0, 0, -1);
    // Reset in the middle of a data wait; a later dmem_ack must not retire.
    run_instr(1, $urandom, 1'b1, 5, 0, 2);

    // Randomized instruction stream within the timeout window.
    repeat (40)
      run_instr(int'($urandom_range(0, TO - 1)), $urandom, rb(),
                int'($urandom_range(0, TO - 1)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Multi-cycle instruction sequencer that owns the PC block's write enable.
- Fetches the instruction at the current PC over a request/acknowledge instruction-memory interface and holds it in an instruction register.
- Optionally waits on a data-memory handshake.
- Retires the instruction by pulsing the PC write enable and the register-file write enable for one cycle.
- Sits between the PC block, instruction/data memory, and decode/execute.

Parameters:
ADDR_W, 32, width of PC / instruction address
TIMEOUT_CYCLES, 255, max consecutive wait cycles before FAULT; 0 disables timeout

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset
pc_value  input  ADDR_W  current PC from PC block
halt_req  input  1  request to stop after current instruction
instr_is_mem  input  1  decoded current instruction needs data memory; sampled in EXEC
imem_req  output  1  instruction memory request, level
imem_addr  output  ADDR_W  registered fetch address
imem_ack  input  1  instruction data valid, single-cycle
imem_rdata  input  32  instruction word
instr_out  output  32  instruction register
instr_valid  output  1  instr_out valid for decode/execute
dmem_req  output  1  data memory request, level
dmem_ack  input  1  data access complete, single-cycle
pc_in_en  output  1  PC write enable, one-cycle pulse at retire
reg_write_en  output  1  register-file write enable, coincident with pc_in_en
fault  output  1  sticky memory timeout flag
state_out  output  3  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, WAIT_I=2, EXEC=3, WAIT_D=4, RETIRE=5, HALT=6, FAULT=7.
- All control outputs decode from the state register (Moore); no combinational path from any input to any output.
- Reset (reset==0 at a rising edge):
  - state <= IDLE; imem_addr <= 0; instr_out <= 0; timeout counter <= 0.
  - All outputs 0; fault cleared.
  - Applies from any state, including mid-handshake; the in-flight request is dropped.
- IDLE: -> HALT if halt_req, else -> FETCH.
- FETCH: imem_addr <= pc_value; -> WAIT_I; counter <= 0.
- WAIT_I: imem_req=1.
  - On imem_ack: instr_out <= imem_rdata; -> EXEC.
  - Otherwise the counter increments.
- EXEC: instr_valid=1, one cycle. -> WAIT_D if instr_is_mem, else -> RETIRE; counter <= 0.
- WAIT_D: dmem_req=1, instr_valid=1.
  - On dmem_ack: -> RETIRE.
  - Otherwise the counter increments.
- RETIRE: pc_in_en=1, reg_write_en=1, instr_valid=1 for exactly one cycle. -> HALT if halt_req, else -> FETCH.
- HALT: all control outputs 0; -> FETCH on the first cycle halt_req==0.
- FAULT: fault=1; all other control outputs 0; held until reset.
- Timeout:
  - Applies when TIMEOUT_CYCLES>0.
  - If the TIMEOUT_CYCLES-th consecutive cycle in WAIT_I or WAIT_D has no ack, the next state is FAULT.
  - An ack on that same cycle wins; no fault.
  - Counter width is clog2(TIMEOUT_CYCLES+1) and saturates.
- Latency, zero-wait memory: non-memory instruction 4 cycles (FETCH, WAIT_I, EXEC, RETIRE); memory instruction 5 cycles minimum.
- imem_ack outside WAIT_I and dmem_ack outside WAIT_D are ignored.
- halt_req is sampled only in IDLE, RETIRE and HALT; an instruction in progress always completes.
- instr_out holds its value until the next imem_ack.
- imem_addr holds from FETCH until the next FETCH.

Optional Feature:
SEQ_PERF_COUNTERS_EN
- Defined: adds outputs cycle_count[31:0] and retired_count[31:0].
  - cycle_count increments every cycle with reset==1.
  - retired_count increments in each RETIRE cycle.
  - Both wrap 0xFFFFFFFF -> 0 and clear on reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
1. Reset, then imem_ack every WAIT_I cycle, instr_is_mem=0, PC block connected -> pc_in_en pulses every 4 cycles; imem_addr sequence 0x0, 0x4, 0x8.
2. imem_ack delayed 3 cycles, imem_rdata=0x00500093 -> instr_out==0x00500093 the cycle after ack; instr_valid the same cycle; pc_in_en 2 cycles after ack.
3. instr_is_mem=1, dmem_ack 2 cycles after entering WAIT_D -> RETIRE the cycle after ack; instruction takes 6 cycles; reg_write_en coincides with pc_in_en.
4. TIMEOUT_CYCLES=8, no imem_ack -> state_out==7 after 8 WAIT_I cycles; fault stays 1 for 20 further cycles; pc_in_en never pulses. Repeat with ack on the 8th wait cycle -> EXEC, fault==0.
5. halt_req=1 asserted during WAIT_I -> instruction completes through RETIRE, then state_out==6. Deassert -> FETCH next cycle with imem_addr==updated PC.
6. reset=0 for one edge during WAIT_D -> next cycle state_out==0, dmem_req==0, instr_out==0, fault==0; a later dmem_ack causes no retire.
